div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Multi-cycle sequencer for RISC-V M-extension DIV/DIVU/REM/REMU. The single-cycle execute stage cannot complete these.
- Execute stage hands the operands over on start_i. The block holds the pipeline through stall_o and runs a 32-iteration restoring radix-2 divide on one shared shift/subtract datapath.
- Returns the result with a one-cycle ready_o strobe, plus destination register address and write enable, toward the register write port.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  execute stage requests a divide; sampled only in IDLE
- funct3_i  input  3  100=DIV, 101=DIVU, 110=REM, 111=REMU
- dividend_i  input  XLEN  rs1 value
- divisor_i  input  XLEN  rs2 value
- rd_addr_i  input  5  destination register
- flush_i  input  1  synchronous abort (branch/jump flush)
- busy_o  output  1  state != IDLE
- stall_o  output  1  hold upstream pipeline
- result_o  output  XLEN  quotient or remainder; valid only while ready_o=1, else 0
- ready_o  output  1  one-cycle completion strobe
- rd_addr_o  output  5  latched rd_addr_i while ready_o=1, else 0
- rd_wen_o  output  1  equals ready_o

Behaviour:
- Reset, asynchronous:
  - state=IDLE.
  - busy_o, ready_o, rd_wen_o, result_o, rd_addr_o = 0.
  - All internal registers (operands, count, quotient, remainder, op, sign flags) = 0.
  - Reset mid-operation drops the operation silently; no ready_o.
- States: IDLE, START, CALC, END.
- IDLE:
  - On start_i=1 and flush_i=0, latch funct3, dividend, divisor and rd_addr, then go to START.
  - start_i outside IDLE is ignored.
- START (1 cycle):
  - Divisor==0: quotient=all ones (0xFFFFFFFF), remainder=dividend, both signed and unsigned; go to END.
  - DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF: quotient=0x80000000, remainder=0; go to END.
  - Otherwise:
    - Signed ops: take absolute values; record quotient sign = sign(dividend) XOR sign(divisor), remainder sign = sign(dividend).
    - Clear count, quotient and remainder; go to CALC.
- CALC (exactly XLEN cycles):
  - Each cycle: shift {remainder, dividend} left by 1. If remainder >= divisor, subtract and shift in quotient bit 1, else 0.
  - Increment count. At count==XLEN-1, go to END.
- END (1 cycle):
  - Apply sign correction to normal-path results: negate if the recorded sign is 1.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) onto result_o.
  - Drive ready_o=1, rd_wen_o=1 and rd_addr_o; go to IDLE. Outputs are registered and zero in every other cycle.
- Latency, with start sampled at edge 0:
  - Normal path: ready_o high in cycle 34 (START 1 + CALC 32 + END 1).
  - Special cases: ready_o high in cycle 2.
- stall_o = (start_i && state==IDLE) || state==START || state==CALC. It is low in END, so upstream advances in the cycle the result writes back.
- flush_i:
  - In any state it forces IDLE at the next edge with no ready_o; it has priority over start_i.
  - In END, flush_i suppresses ready_o/rd_wen_o in that cycle.
- Back-to-back: a new start_i may be sampled in the first cycle after END (IDLE).

Optional Feature:
- DIV_EARLY_OUT_EN defined: in START, if |dividend| < |divisor| (unsigned magnitudes, divisor non-zero), set quotient=0 and remainder=original dividend, skip CALC and go to END. Latency 2.
- Undefined: such operands take the full 34-cycle path; the result is identical either way.

Test Plan:
- DIVU 100/7 -> ready_o in cycle 34, result 14, rd_addr_o=rd_addr_i, single-cycle strobe.
- REM -7/2 (0xFFFFFFF9, 2) -> result 0xFFFFFFFF (-1); DIV same operands -> 0xFFFFFFFD (-3).
- DIV x/0 -> 0xFFFFFFFF in cycle 2; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Assert flush_i in CALC cycle 10 -> IDLE next cycle, no ready_o; new DIVU 9/3 immediately after -> 3.
- Drop rst_n in CALC -> all outputs 0 immediately, no ready_o; start_i pulsed while busy is ignored (one result only).
- DIVU 3/10 -> result 0: cycle 2 with DIV_EARLY_OUT_EN, cycle 34 without; stall_o low in the ready cycle.

Source files
------------

// File: rtl/div_ctrl.sv
// Sequencer for RV32M DIV/DIVU/REM/REMU: a restoring radix-2 divider that takes XLEN+2 cycles, or 2 cycles for the special cases.
// The upstream pipeline is held with stall_o until the cycle in which the result is written back.
// Defining DIV_EARLY_OUT_EN lets a divide with |dividend| < |divisor| skip the iteration loop.
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(XLEN-1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_CALC, S_END} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] dvd_q, dvs_q, rem_q, quo_q;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      rd_q;
  logic            q_neg_q, r_neg_q;

  logic            signed_op, is_rem, div_zero, ovf, early_out, take;
  logic [XLEN-1:0] abs_dvd, abs_dvs, res_sel;
  logic [XLEN:0]   trial, diff;

  assign signed_op = (op_q == F_DIV) || (op_q == F_REM);
  assign is_rem    = (op_q == F_REM) || (op_q == F_REMU);
  assign abs_dvd   = (signed_op && dvd_q[XLEN-1]) ? -dvd_q : dvd_q;
  assign abs_dvs   = (signed_op && dvs_q[XLEN-1]) ? -dvs_q : dvs_q;
  assign div_zero  = (dvs_q == '0);
  assign ovf       = signed_op && (dvd_q == INT_MIN) && (dvs_q == '1);
`ifdef DIV_EARLY_OUT_EN
  assign early_out = (abs_dvd < abs_dvs);
`else
  assign early_out = 1'b0;
`endif

  // One restoring step: the remainder is widened by a bit so divisors above 2^(XLEN-1) compare correctly.
  assign trial = {rem_q, dvd_q[XLEN-1]};
  assign take  = (trial >= {1'b0, dvs_q});
  assign diff  = trial - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_i) state_d = S_START;
        S_START: state_d = (div_zero || ovf || early_out) ? S_END : S_CALC;
        S_CALC:  if (cnt_q == LAST_CNT) state_d = S_END;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            op_q  <= funct3_i;
            dvd_q <= dividend_i;
            dvs_q <= divisor_i;
            rd_q  <= rd_addr_i;
          end
        end
        S_START: begin
          // Special cases load final values directly, so sign correction must be disabled.
          q_neg_q <= 1'b0;
          r_neg_q <= 1'b0;
          if (div_zero) begin
            quo_q <= '1;
            rem_q <= dvd_q;
          end else if (ovf) begin
            quo_q <= INT_MIN;
            rem_q <= '0;
          end else if (early_out) begin
            quo_q <= '0;
            rem_q <= dvd_q;
          end else begin
            dvd_q   <= abs_dvd;
            dvs_q   <= abs_dvs;
            q_neg_q <= signed_op && (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
            r_neg_q <= signed_op && dvd_q[XLEN-1];
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
          end
        end
        S_CALC: begin
          dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
          rem_q <= take ? diff[XLEN-1:0] : trial[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], take};
          cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (is_rem) res_sel = r_neg_q ? -rem_q : rem_q;
    else        res_sel = q_neg_q ? -quo_q : quo_q;
    ready_o   = (state_q == S_END) && !flush_i;
    rd_wen_o  = ready_o;
    result_o  = ready_o ? res_sel : '0;
    rd_addr_o = ready_o ? rd_q : '0;
    busy_o    = (state_q != S_IDLE);
    stall_o   = (start_i && (state_q == S_IDLE)) || (state_q == S_START) || (state_q == S_CALC);
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus random operations checked against an arithmetic reference.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] dividend_i, divisor_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o, stall_o, ready_o, rd_wen_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int vecs = 0;
  int errs = 0;

  // observations captured by run_op
  logic        o_seen, o_wen, o_stall, o_stall_req;
  int          o_lat;
  logic [31:0] o_res;
  logic [4:0]  o_addr;

  always #5 clk = ~clk;

  div_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .funct3_i(funct3_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .rd_addr_i(rd_addr_i),
    .flush_i(flush_i), .busy_o(busy_o), .stall_o(stall_o), .result_o(result_o),
    .ready_o(ready_o), .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o)
  );

  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
    case (f)
      3'b100:  return sa / sb;
      3'b101:  return a / b;
      3'b110:  return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    if (b == 0) return 2;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    ma = (!f[0] && a[31]) ? -a : a;
    mb = (!f[0] && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 2;
`endif
    return 34;
  endfunction

  // Presents one operation in the current cycle (start sampled at the next edge) and waits for its strobe.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(posedge clk); #1;
    start_i = 1'b1; funct3_i = f; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    #1 o_stall_req = stall_o;
    @(posedge clk); #1;
    start_i = 1'b0; dividend_i = $urandom; divisor_i = $urandom; rd_addr_i = 5'($urandom);
    o_seen = 1'b0; o_lat = 0; o_res = '0; o_addr = '0; o_wen = 1'b0; o_stall = 1'b1;
    for (int n = 1; n <= 60 && !o_seen; n++) begin
      @(negedge clk);
      if (ready_o) begin
        o_seen = 1'b1; o_lat = n; o_res = result_o; o_addr = rd_addr_o; o_wen = rd_wen_o; o_stall = stall_o;
      end
    end
  endtask

  task automatic gen_op(output logic [2:0] f, output logic [31:0] a, output logic [31:0] b);
    int ka, kb;
    logic [1:0] lo;
    lo = 2'($urandom_range(0, 3));
    f  = {1'b1, lo};
    ka = $urandom_range(0, 4);
    kb = $urandom_range(0, 6);
    a  = (ka == 0) ? 32'h8000_0000 : (ka == 1) ? 32'($urandom_range(0, 50)) : $urandom;
    b  = (kb == 0) ? 32'h0 : (kb == 1) ? 32'hFFFF_FFFF : (kb <= 3) ? 32'($urandom_range(1, 20)) :
         (kb == 4) ? -32'($urandom_range(1, 20)) : $urandom;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; funct3_i = '0;
    dividend_i = '0; divisor_i = '0; rd_addr_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({busy_o, stall_o, ready_o, rd_wen_o, result_o, rd_addr_o} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: busy=%0b stall=%0b ready=%0b wen=%0b result=%h rd=%0d, required all 0",
               busy_o, stall_o, ready_o, rd_wen_o, result_o, rd_addr_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [2:0]  tf [8] = '{3'b101, 3'b110, 3'b100, 3'b100, 3'b111, 3'b100, 3'b110, 3'b101};
    logic [31:0] ta [8] = '{100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 5, 32'h1234, 32'h8000_0000, 32'h8000_0000, 3};
    logic [31:0] tb [8] = '{7, 2, 2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10};
    logic [31:0] te [8] = '{14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 0, 0};
`ifdef DIV_EARLY_OUT_EN
    int          tl [8] = '{34, 34, 34, 2, 2, 2, 2, 2};
`else
    int          tl [8] = '{34, 34, 34, 2, 2, 2, 2, 34};
`endif
    for (int i = 0; i < 8; i++) begin
      run_op(tf[i], ta[i], tb[i], 5'(i + 3));
      vecs++;
      if (!o_seen || o_res !== te[i] || o_lat != tl[i]) begin
        errs++;
        $display("FAIL directed_%0d: seen=%0b result=%h cycle=%0d, required result=%h cycle=%0d",
                 i, o_seen, o_res, o_lat, te[i], tl[i]);
      end
      vecs++;
      if (o_addr !== 5'(i + 3) || o_wen !== 1'b1 || o_stall !== 1'b0) begin
        errs++;
        $display("FAIL directed_wb_%0d: rd=%0d wen=%0b stall=%0b, required rd=%0d wen=1 stall=0",
                 i, o_addr, o_wen, o_stall, i + 3);
      end
      @(negedge clk);
      vecs++;
      if (ready_o !== 1'b0 || rd_wen_o !== 1'b0 || result_o !== '0 || busy_o !== 1'b0) begin
        errs++;
        $display("FAIL strobe_width_%0d: ready=%0b wen=%0b result=%h busy=%0b, required all 0",
                 i, ready_o, rd_wen_o, result_o, busy_o);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    logic [4:0]  rd;
    for (int i = 0; i < 40; i++) begin
      gen_op(f, a, b);
      rd  = 5'($urandom);
      exp = ref_div(f, a, b);
      run_op(f, a, b, rd);
      vecs++;
      if (!o_seen || o_res !== exp || o_lat != ref_lat(f, a, b) || o_addr !== rd) begin
        errs++;
        $display("FAIL random_%0d f=%b a=%h b=%h: result=%h cycle=%0d rd=%0d, required result=%h cycle=%0d rd=%0d",
                 i, f, a, b, o_res, o_lat, o_addr, exp, ref_lat(f, a, b), rd);
      end
      vecs++;
      if (o_stall_req !== 1'b1) begin
        errs++;
        $display("FAIL stall_on_start_%0d: stall=%0b, required 1", i, o_stall_req);
      end
    end
  endtask

  task automatic test_flush;
    @(posedge clk); #1;
    start_i = 1'b1; funct3_i = 3'b101; dividend_i = 100; divisor_i = 7; rd_addr_i = 5'd4;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    vecs++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
      errs++;
      $display("FAIL flush_calc: busy=%0b ready=%0b, required 0 0", busy_o, ready_o);
    end
    run_op(3'b101, 9, 3, 5'd11);
    vecs++;
    if (!o_seen || o_res !== 32'd3 || o_lat != 34 || o_addr !== 5'd11) begin
      errs++;
      $display("FAIL after_flush: result=%h cycle=%0d rd=%0d, required result=3 cycle=34 rd=11", o_res, o_lat, o_addr);
    end
    // flush landing on the write-back cycle
    @(posedge clk); #1;
    start_i = 1'b1; funct3_i = 3'b100; dividend_i = 77; divisor_i = 0; rd_addr_i = 5'd6;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    flush_i = 1'b1;
    #1;
    vecs++;
    if (ready_o !== 1'b0 || rd_wen_o !== 1'b0 || result_o !== '0 || rd_addr_o !== '0) begin
      errs++;
      $display("FAIL flush_end: ready=%0b wen=%0b result=%h rd=%0d, required all 0", ready_o, rd_wen_o, result_o, rd_addr_o);
    end
    @(posedge clk); #1;
    flush_i = 1'b0;
    vecs++;
    if (busy_o !== 1'b0) begin
      errs++;
      $display("FAIL flush_end_idle: busy=%0b, required 0", busy_o);
    end
  endtask

  task automatic test_reset_mid;
    int strobes;
    @(posedge clk); #1;
    start_i = 1'b1; funct3_i = 3'b100; dividend_i = 32'hFFFF_FF00; divisor_i = 3; rd_addr_i = 5'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({busy_o, stall_o, ready_o, rd_wen_o, result_o, rd_addr_o} !== '0) begin
      errs++;
      $display("FAIL reset_mid: busy=%0b stall=%0b ready=%0b wen=%0b result=%h rd=%0d, required all 0",
               busy_o, stall_o, ready_o, rd_wen_o, result_o, rd_addr_o);
    end
    #3 rst_n = 1'b1;
    strobes = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) strobes++;
    end
    vecs++;
    if (strobes != 0) begin
      errs++;
      $display("FAIL reset_mid_no_ready: strobes=%0d, required 0", strobes);
    end
  endtask

  task automatic test_start_ignored;
    int strobes;
    logic [31:0] res;
    logic [4:0]  rd;
    @(posedge clk); #1;
    start_i = 1'b1; funct3_i = 3'b101; dividend_i = 1000; divisor_i = 10; rd_addr_i = 5'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 start_i = 1'b1; funct3_i = 3'b101; dividend_i = 5; divisor_i = 1; rd_addr_i = 5'd9;
    @(posedge clk); #1;
    start_i = 1'b0;
    strobes = 0; res = '0; rd = '0;
    repeat (70) begin
      @(negedge clk);
      if (ready_o) begin
        strobes++; res = result_o; rd = rd_addr_o;
      end
    end
    vecs++;
    if (strobes != 1 || res !== 32'd100 || rd !== 5'd7) begin
      errs++;
      $display("FAIL start_while_busy: strobes=%0d result=%h rd=%0d, required 1 strobe result=00000064 rd=7",
               strobes, res, rd);
    end
  endtask

  initial begin
    o_stall_req = 1'b0;
    test_reset;
    test_directed;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    test_start_ignored;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
